// File: rtl/fp_misc_sched.sv
// fp_misc_sched: two issue ports share one single-precision misc unit (classify,
// sign-inject, min/max) via round-robin; the result sits in one valid/ready register.
module fp_misc_sched #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [31:0]      req_rs1_0,
  input  logic [31:0]      req_rs2_0,
  input  logic [31:0]      req_rs1_1,
  input  logic [31:0]      req_rs2_1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_src,
  output logic             res_nv
);

  localparam logic [2:0]  OP_FCLASS = 3'd0;
  localparam logic [2:0]  OP_FSGNJ  = 3'd1;
  localparam logic [2:0]  OP_FSGNJN = 3'd2;
  localparam logic [2:0]  OP_FSGNJX = 3'd3;
  localparam logic [2:0]  OP_FMIN   = 3'd4;
  localparam logic [2:0]  OP_FMAX   = 3'd5;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  // Class index 0..9: -inf, -norm, -sub, -0, +0, +sub, +norm, +inf, sNaN, qNaN.
  function automatic logic [3:0] fclass_idx(input logic [31:0] x);
    logic        sgn;
    logic [7:0]  ex;
    logic [22:0] man;
    sgn = x[31];
    ex  = x[30:23];
    man = x[22:0];
    if (ex == 8'hFF) begin
      if (man == '0)   fclass_idx = sgn ? 4'd0 : 4'd7;
      else if (man[22]) fclass_idx = 4'd9;
      else             fclass_idx = 4'd8;
    end else if (ex == 8'h00) begin
      if (man == '0) fclass_idx = sgn ? 4'd3 : 4'd4;
      else           fclass_idx = sgn ? 4'd2 : 4'd5;
    end else begin
      fclass_idx = sgn ? 4'd1 : 4'd6;
    end
  endfunction

  logic             rr_ptr;
  logic             sel;
  logic             can_accept;
  logic             accept;

  logic [2:0]       op_s;
  logic [31:0]      a_s;
  logic [31:0]      b_s;
  logic [TAG_W-1:0] tag_s;

  logic [3:0]       cls_a;
  logic [3:0]       cls_b;
  logic             a_nan;
  logic             b_nan;
  logic             a_snan;
  logic             b_snan;
  logic             a_lt_b;
  logic [31:0]      minmax_val;
  logic [31:0]      exec_data;
  logic             exec_nv;

  always_comb begin
    sel = 1'b0;
    if (req_valid == 2'b11) sel = rr_ptr;
    else                    sel = req_valid[1];
  end

  // Reset is folded in so nothing is granted while the block is held in reset.
  assign can_accept = !resetn && !flush && (!res_valid || res_ready);
  assign accept     = can_accept && (req_valid != 2'b00);
  assign req_ready  = {accept && sel, accept && !sel};

  assign op_s  = sel ? req_op1   : req_op0;
  assign a_s   = sel ? req_rs1_1 : req_rs1_0;
  assign b_s   = sel ? req_rs2_1 : req_rs2_0;
  assign tag_s = sel ? req_tag1  : req_tag0;

  always_comb begin
    cls_a  = fclass_idx(a_s);
    cls_b  = fclass_idx(b_s);
    a_nan  = (cls_a >= 4'd8);
    b_nan  = (cls_b >= 4'd8);
    a_snan = (cls_a == 4'd8);
    b_snan = (cls_b == 4'd8);

    // Sign-magnitude order; differing signs also puts -0 below +0.
    if (a_s[31] != b_s[31]) a_lt_b = a_s[31];
    else if (a_s[31])       a_lt_b = (a_s[30:0] > b_s[30:0]);
    else                    a_lt_b = (a_s[30:0] < b_s[30:0]);

    if (a_nan && b_nan)      minmax_val = CANON_NAN;
    else if (a_nan)          minmax_val = b_s;
    else if (b_nan)          minmax_val = a_s;
    else if (op_s == OP_FMIN) minmax_val = a_lt_b ? a_s : b_s;
    else                     minmax_val = a_lt_b ? b_s : a_s;
  end

  always_comb begin
    exec_data = '0;
    exec_nv   = 1'b0;
    case (op_s)
      OP_FCLASS: exec_data = 32'd1 << cls_a;
      OP_FSGNJ:  exec_data = {b_s[31], a_s[30:0]};
      OP_FSGNJN: exec_data = {~b_s[31], a_s[30:0]};
      OP_FSGNJX: exec_data = {a_s[31] ^ b_s[31], a_s[30:0]};
      OP_FMIN, OP_FMAX: begin
        exec_data = minmax_val;
        exec_nv   = a_snan | b_snan;
      end
      default:   exec_nv = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      res_src   <= 1'b0;
      res_nv    <= 1'b0;
      rr_ptr    <= 1'b0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (accept) begin
      res_valid <= 1'b1;
      res_data  <= exec_data;
      res_tag   <= tag_s;
      res_src   <= sel;
      res_nv    <= exec_nv;
      rr_ptr    <= ~sel;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_misc_sched.sv
// Scoreboard bench for fp_misc_sched: a predictor models arbitration and FP results
// from the rules, a monitor compares every presented result against the queue head.
module tb_fp_misc_sched;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2:0]    req_op0, req_op1;
  logic [31:0]   req_rs1_0, req_rs2_0, req_rs1_1, req_rs2_1;
  logic [TW-1:0] req_tag0, req_tag1;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic [TW-1:0] res_tag;
  logic          res_src;
  logic          res_nv;

  fp_misc_sched #(.TAG_W(TW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_rs1_0(req_rs1_0), .req_rs2_0(req_rs2_0),
    .req_rs1_1(req_rs1_1), .req_rs2_1(req_rs2_1),
    .req_tag0(req_tag0), .req_tag1(req_tag1),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag),
    .res_src(res_src), .res_nv(res_nv)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    logic          src;
    logic          nv;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  logic       m_valid;
  logic       m_rr;
  logic [1:0] m_acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, expv, $time);
    end
  endtask

  // Reference classification by magnitude ranges.
  function automatic int cls(input logic [31:0] x);
    logic [30:0] mag;
    mag = x[30:0];
    if (mag >= 31'h7FC0_0000) return 9;
    if (mag >  31'h7F80_0000) return 8;
    if (mag == 31'h7F80_0000) return x[31] ? 0 : 7;
    if (mag >= 31'h0080_0000) return x[31] ? 1 : 6;
    if (mag != 0)             return x[31] ? 2 : 5;
    return x[31] ? 3 : 4;
  endfunction

  // Total order key: negatives mirrored below zero, -0 maps to -1.
  function automatic longint fkey(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? (-m - 1) : m;
  endfunction

  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic        nv;
    bit          an, bn;
    d = 32'h0; nv = 1'b0;
    an = cls(a) >= 8;
    bn = cls(b) >= 8;
    case (op)
      3'd0: d = 32'h1 << cls(a);
      3'd1: d = {b[31], a[30:0]};
      3'd2: d = {~b[31], a[30:0]};
      3'd3: d = {a[31] ^ b[31], a[30:0]};
      3'd4, 3'd5: begin
        nv = (cls(a) == 8) || (cls(b) == 8);
        if (an && bn)      d = 32'h7FC0_0000;
        else if (an)       d = b;
        else if (bn)       d = a;
        else if (op == 3'd4) d = (fkey(a) <= fkey(b)) ? a : b;
        else               d = (fkey(a) >= fkey(b)) ? a : b;
      end
      default: nv = 1'b1;
    endcase
    return {nv, d};
  endfunction

  // Predictor: arbitration model, req_ready/res_valid checks, expected-result push.
  always @(negedge clk or posedge resetn) begin
    if (resetn) begin
      m_valid = 1'b0;
      m_rr    = 1'b0;
      m_acc   = 2'b00;
    end else begin
      bit          can;
      int          win;
      logic [1:0]  er;
      logic [32:0] r;
      exp_t        e;
      chk("res_valid", {63'h0, res_valid}, {63'h0, m_valid});
      can = !flush && (!m_valid || res_ready);
      if (req_valid == 2'b11) win = int'(m_rr);
      else                    win = req_valid[0] ? 0 : 1;
      er = (can && req_valid != 2'b00) ? (2'b01 << win) : 2'b00;
      chk("req_ready", {62'h0, req_ready}, {62'h0, er});
      m_acc = er;
      if (er != 2'b00) begin
        if (win == 0) begin
          r = model(req_op0, req_rs1_0, req_rs2_0);
          e.tag = req_tag0;
        end else begin
          r = model(req_op1, req_rs1_1, req_rs2_1);
          e.tag = req_tag1;
        end
        e.data = r[31:0];
        e.nv   = r[32];
        e.src  = (win == 1);
        sbq.push_back(e);
        m_rr    = (win == 0);
        m_valid = 1'b1;
      end else if (flush || res_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: every cycle a result is presented it must equal the queue head.
  always @(negedge clk or posedge resetn) begin
    if (resetn) begin
      sbq.delete();
    end else if (res_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=res_valid=1 required=no pending result t=%0t", $time);
      end else begin
        chk("res_data", {32'h0, res_data}, {32'h0, sbq[0].data});
        chk("res_tag",  {59'h0, res_tag},  {59'h0, sbq[0].tag});
        chk("res_src",  {63'h0, res_src},  {63'h0, sbq[0].src});
        chk("res_nv",   {63'h0, res_nv},   {63'h0, sbq[0].nv});
        if (flush || res_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic set_port(input int p, input logic v, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
    if (p == 0) begin
      req_valid[0] = v; req_op0 = op; req_rs1_0 = a; req_rs2_0 = b; req_tag0 = t;
    end else begin
      req_valid[1] = v; req_op1 = op; req_rs1_1 = a; req_rs2_1 = b; req_tag1 = t;
    end
  endtask

  logic [31:0] specials [14] = '{32'hFF800000, 32'hBF800000, 32'h80000001, 32'h80000000,
                                 32'h00000000, 32'h00000001, 32'h3F800000, 32'h7F800000,
                                 32'h7F800001, 32'h7FC00000, 32'hFFC00001, 32'hFF800001,
                                 32'h40000000, 32'hC0000000};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 13)];
    return $urandom;
  endfunction

  task automatic single(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic env, input string nm);
    @(posedge clk); #1;
    set_port(1 - p, 1'b0, 3'd0, 32'h0, 32'h0, '0);
    set_port(p, 1'b1, op, a, b, 5'($urandom));
    res_ready = 1'b1;
    flush = 1'b0;
    @(posedge clk); #1;
    set_port(p, 1'b0, op, a, b, '0);
    @(negedge clk);
    chk({nm, "_valid"}, {63'h0, res_valid}, 64'h1);
    chk(nm, {32'h0, res_data}, {32'h0, ed});
    chk({nm, "_nv"}, {63'h0, res_nv}, {63'h0, env});
  endtask

  logic [31:0] cvals [10] = '{32'hFF800000, 32'hBF800000, 32'h80000001, 32'h80000000, 32'h00000000,
                              32'h00000001, 32'h3F800000, 32'h7F800000, 32'h7F800001, 32'h7FC00000};

  initial begin
    resetn = 1'b1;
    flush = 1'b0;
    res_ready = 1'b0;
    req_valid = 2'b11;
    req_op0 = 3'd0; req_op1 = 3'd0;
    req_rs1_0 = 32'h0; req_rs2_0 = 32'h0; req_rs1_1 = 32'h0; req_rs2_1 = 32'h0;
    req_tag0 = '0; req_tag1 = '0;

    @(negedge clk);
    chk("rst_valid", {63'h0, res_valid}, 64'h0);
    chk("rst_data",  {32'h0, res_data},  64'h0);
    chk("rst_tag",   {59'h0, res_tag},   64'h0);
    chk("rst_src",   {63'h0, res_src},   64'h0);
    chk("rst_nv",    {63'h0, res_nv},    64'h0);
    chk("rst_ready", {62'h0, req_ready}, 64'h0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    resetn = 1'b0;

    for (int i = 0; i < 10; i++)
      single(0, 3'd0, cvals[i], 32'h0, 32'h1 << i, 1'b0, "fclass");

    single(0, 3'd4, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, "fmin_zero");
    single(1, 3'd5, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b1, "fmax_snan");
    single(0, 3'd4, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b0, "fmin_qnan2");
    single(1, 3'd3, 32'hBF800000, 32'hBF800000, 32'h3F800000, 1'b0, "fsgnjx");
    single(0, 3'd2, 32'h3F800000, 32'h3F800000, 32'hBF800000, 1'b0, "fsgnjn");
    single(1, 3'd6, 32'h3F800000, 32'h0, 32'h0, 1'b1, "reserved");

    // Round-robin: both ports always valid, fresh operands every cycle.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      res_ready = 1'b1;
      set_port(0, 1'b1, 3'd1, pick(), pick(), 5'(2 * c));
      set_port(1, 1'b1, 3'd5, pick(), pick(), 5'(2 * c + 1));
    end

    // Backpressure for 3 cycles, then release with both ports still pending.
    @(posedge clk); #1;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b1;

    // Flush while a result is held and port 1 requests.
    set_port(0, 1'b1, 3'd0, 32'h3F800000, 32'h0, 5'd3);
    set_port(1, 1'b0, 3'd0, 32'h0, 32'h0, '0);
    @(posedge clk); #1;
    set_port(0, 1'b0, 3'd0, 32'h0, 32'h0, '0);
    set_port(1, 1'b1, 3'd4, 32'h40000000, 32'hC0000000, 5'd9);
    res_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_valid", {63'h0, res_valid}, 64'h0);
    set_port(0, 1'b1, 3'd0, 32'h80000000, 32'h0, 5'd4);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    set_port(0, 1'b1, 3'd1, 32'h12345678, 32'h80000000, 5'd5);
    res_ready = 1'b0;

    // Asynchronous reset pulse between edges while a result is held.
    @(posedge clk); #2;
    resetn = 1'b1;
    #1;
    chk("arst_valid", {63'h0, res_valid}, 64'h0);
    chk("arst_data",  {32'h0, res_data},  64'h0);
    chk("arst_tag",   {59'h0, res_tag},   64'h0);
    chk("arst_src",   {63'h0, res_src},   64'h0);
    chk("arst_nv",    {63'h0, res_nv},    64'h0);
    chk("arst_ready", {62'h0, req_ready}, 64'h0);
    #1 resetn = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_tie", {62'h0, req_ready}, 64'h1);

    // Random traffic; requesters hold their fields until accepted.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!(req_valid[p] && !m_acc[p]))
          set_port(p, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom));
      end
      res_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 24) == 0;
    end

    @(posedge clk); #1;
    req_valid = 2'b00;
    flush = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 20 && sbq.size() != 0; c++) @(posedge clk);
    #1;
    chk("drain", 64'(sbq.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_misc_sched.md
# fp_misc_sched

Round-robin scheduler that shares one FP miscellaneous datapath (classify, sign-inject, min/max) between two requesters, such as the integer-pipe and FP-pipe issue ports. It arbitrates each cycle, computes the selected operation on the granted operands, and holds the result in a single output register with a valid/ready handshake. The output register is the only pipeline stage. Single-precision operands only.

## Interface
- TAG_W, 5, width of the requester tag carried through to the result
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-high reset: resetn=1 clears all state immediately, independent of clk
- flush  in  1  synchronous kill of the in-flight result and of this cycle's acceptance
- req_valid  in  2  per-port request valid (bit p = port p)
- req_ready  out  2  per-port grant/accept (combinational)
- req_op0, req_op1  in  3 each  operation: 0 FCLASS, 1 FSGNJ, 2 FSGNJN, 3 FSGNJX, 4 FMIN, 5 FMAX; 6 and 7 reserved
- req_rs1_0, req_rs2_0, req_rs1_1, req_rs2_1  in  32 each  operands
- req_tag0, req_tag1  in  TAG_W each  requester tags
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  32  result
- res_tag  out  TAG_W  tag of the producing request
- res_src  out  1  port that produced the result
- res_nv  out  1  invalid-operation flag (sNaN input to FMIN/FMAX)

## Operation
- Class index of rs1 per bit pattern:
  - 0: -inf
  - 1: -normal
  - 2: -subnormal
  - 3: -0
  - 4: +0
  - 5: +subnormal
  - 6: +normal
  - 7: +inf
  - 8: sNaN (exp=FF, mant≠0, mant[22]=0)
  - 9: qNaN (exp=FF, mant[22]=1)
- Classification is exhaustive and mutually exclusive. Sign is ignored for NaN classes.
- FCLASS: res_data = 32'b1 << index (bits 31:10 zero). res_nv=0.
- FSGNJ / FSGNJN / FSGNJX: res_data = {s, rs1[30:0]}, where s = rs2[31], ~rs2[31], or rs1[31]^rs2[31] respectively. res_nv=0.
- FMIN / FMAX:
  - Both operands NaN: 32'h7FC00000.
  - Exactly one NaN: the other operand.
  - Otherwise: sign-magnitude compare, with -0 ordered below +0.
  - res_nv=1 if either operand is an sNaN.
- Reserved op: res_data=0, res_nv=1.
- Accept condition: can_accept = !flush && (!res_valid || res_ready).
- Grant:
  - Only one valid port: that port wins.
  - Both valid: port rr_ptr wins.
  - req_ready[p] = can_accept && grant[p]. At most one bit of req_ready is set.
- rr_ptr update: on acceptance from port p, rr_ptr ← ~p. The pointer is unchanged when no request is accepted.
- Output register loads {data, tag, src, nv} on acceptance and sets res_valid.
  - res_valid clears on res_valid && res_ready with no new acceptance.
  - res_valid clears on flush.
- Operand, op and tag inputs are sampled only in the accepting cycle. Requesters hold them stable while req_valid=1 and req_ready=0.

## Timing
- Latency: request accepted at edge N → res_valid=1 with its result after edge N, visible in cycle N+1.
- Throughput: one result per cycle while res_ready=1.
- Backpressure: while res_valid=1 and res_ready=0:
  - req_ready=0.
  - All output fields hold stable.
  - rr_ptr holds.
- Simultaneous pop and accept in one cycle: the register is overwritten with the new result and res_valid stays 1.
- flush has priority over everything:
  - res_valid=0 after the edge.
  - No acceptance that cycle; req_ready=0.
  - rr_ptr unchanged.
- Reset values:
  - res_valid=0, res_data=0, res_tag=0, res_src=0, res_nv=0, rr_ptr=0.
  - resetn asserted mid-transaction drops the in-flight result.
  - req_ready=0 while resetn=1.
- First cycle after reset release: port 0 wins a tie.

## Test plan
- Classify sweep: port 0 FCLASS with rs1 ∈ {FF800000, BF800000, 80000001, 80000000, 00000000, 00000001, 3F800000, 7F800000, 7F800001, 7FC00000} → res_data 1, 2, 4, … 0x200 in order, each one cycle after its accept; res_nv=0.
- Round-robin: both ports valid continuously with res_ready=1 → grants 0, 1, 0, 1…; res_src alternates; res_tag matches the producing port.
- Backpressure: hold res_ready=0 for 3 cycles with both ports requesting → req_ready=00 and res_data/res_tag stable; on release, the pending winner is accepted in the same cycle the held result pops.
- Min/max edge cases:
  - FMIN(80000000, 00000000) → 80000000.
  - FMAX(7F800001, 3F800000) → 3F800000 with res_nv=1.
  - FMIN(7FC00000, 7FC00000) → 7FC00000 with res_nv=0.
- Sign inject: FSGNJX(BF800000, BF800000) → 3F800000; FSGNJN(3F800000, 3F800000) → BF800000.
- Flush and reset:
  - flush with res_valid=1 and port 1 requesting → res_valid=0 next cycle; port 1 not accepted; rr_ptr unchanged.
  - resetn pulse mid-stream (asynchronous, between edges) → all outputs go to zero immediately.
